param_cache_control: RTL and testbench

Control FSM for a 2-way set-associative, write-back, write-allocate cache built around the parameterised data array.
- Holds tag, valid, dirty and LRU state internally.
- Sequences the data array's read/write-enable/index/data-select controls.
- Handles the CPU-side request/response handshake and the physical-memory line writeback/fill handshake.
- Sits between the CPU memory port and the cacheline adaptor.

---
 rtl/param_cache_control.sv | 180 ++++++++++++++++++
 tb/tb_param_cache_control.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache_control.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate cache.
// Owns tag/valid/dirty/LRU state and sequences the data array and line memory port.
module param_cache_control #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [31:0]                  mem_address,
  input  logic [3:0]                   mem_byte_enable,
  output logic                         mem_resp,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [31:0]                  pmem_address,
  input  logic                         pmem_resp,
  output logic [num_ways-1:0]          da_read,
  output logic [num_ways*(2**s_offset)-1:0] da_write_en,
  output logic [s_index-1:0]           da_index,
  output logic                         da_datain_sel,
  output logic                         way_sel
);

  localparam int s_mask   = 2**s_offset;
  localparam int num_sets = 2**s_index;
  localparam int tag_w    = 32 - s_offset - s_index;
  localparam int word_w   = s_offset - 2;

  generate
    if (num_ways != 2) begin : g_bad_ways
      $error("param_cache_control supports num_ways == 2 only");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;
  logic [num_sets-1:0][1:0][tag_w-1:0] tag_q, tag_d;
  logic [num_sets-1:0][1:0]            valid_q, valid_d;
  logic [num_sets-1:0][1:0]            dirty_q, dirty_d;
  logic [num_sets-1:0]                 lru_q, lru_d;

  logic [tag_w-1:0]   req_tag_s;
  logic [s_index-1:0] req_idx_s;
  logic [word_w-1:0]  req_word_s;
  logic [1:0]         hit_s;
  logic               hit_way_s;
  logic               pick_s;
  logic [s_mask-1:0]  word_we_s;
  logic               unused_s;

  assign req_tag_s  = mem_address[31:s_offset+s_index];
  assign req_idx_s  = mem_address[s_offset+s_index-1:s_offset];
  assign req_word_s = mem_address[s_offset-1:2];
  assign unused_s   = ^mem_address[1:0];
  assign da_index   = req_idx_s;

  assign hit_s[0]  = valid_q[req_idx_s][0] && (tag_q[req_idx_s][0] == req_tag_s);
  assign hit_s[1]  = valid_q[req_idx_s][1] && (tag_q[req_idx_s][1] == req_tag_s);
  assign hit_way_s = hit_s[1];
  assign word_we_s = {{(s_mask-4){1'b0}}, mem_byte_enable} << {req_word_s, 2'b00};

  // Victim choice: fill an invalid way first, otherwise evict the LRU way.
  assign pick_s = !valid_q[req_idx_s][0] ? 1'b0 :
                  (!valid_q[req_idx_s][1] ? 1'b1 : lru_q[req_idx_s]);

  // Next-state, array bookkeeping and all control outputs.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    lru_d         = lru_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = 32'h0000_0000;
    da_read       = {num_ways{1'b0}};
    da_write_en   = {(num_ways*s_mask){1'b0}};
    da_datain_sel = 1'b0;
    way_sel       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end

      CHECK: begin
        da_read = {num_ways{1'b1}};
        if (hit_s != 2'b00) begin
          mem_resp             = 1'b1;
          way_sel              = hit_way_s;
          lru_d[req_idx_s]     = ~hit_way_s;
          state_d              = IDLE;
          if (mem_write) begin
            da_write_en[{hit_way_s, {s_offset{1'b0}}} +: s_mask] = word_we_s;
            dirty_d[req_idx_s][hit_way_s] = 1'b1;
          end else begin
            dirty_d[req_idx_s][hit_way_s] = dirty_q[req_idx_s][hit_way_s];
          end
        end else if (mem_read || mem_write) begin
          victim_d = pick_s;
          if (valid_q[req_idx_s][pick_s] && dirty_q[req_idx_s][pick_s]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WRITEBACK: begin
        da_read      = {num_ways{1'b1}};
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx_s][victim_q], req_idx_s, {s_offset{1'b0}}};
        way_sel      = victim_q;
        if (pmem_resp) begin
          dirty_d[req_idx_s][victim_q] = 1'b0;
          state_d                      = FILL;
        end else begin
          state_d = WRITEBACK;
        end
      end

      FILL: begin
        pmem_read     = 1'b1;
        pmem_address  = {req_tag_s, req_idx_s, {s_offset{1'b0}}};
        da_datain_sel = 1'b1;
        // The fill line is written in the same cycle the memory returns it.
        if (pmem_resp) begin
          da_write_en[{victim_q, {s_offset{1'b0}}} +: s_mask] = {s_mask{1'b1}};
          tag_d[req_idx_s][victim_q]   = req_tag_s;
          valid_d[req_idx_s][victim_q] = 1'b1;
          dirty_d[req_idx_s][victim_q] = 1'b0;
          state_d                      = CHECK;
        end else begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and tag/valid/dirty/LRU arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      tag_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      lru_q    <= lru_d;
    end
  end

endmodule

// File: tb/tb_param_cache_control.sv
// Self-checking bench for param_cache_control: directed table, reset-in-fill
// sequence, and randomized requests checked against a cache-behaviour model.
module tb_param_cache_control;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic        pmem_resp;
  logic [1:0]  da_read;
  logic [63:0] da_write_en;
  logic [2:0]  da_index;
  logic        da_datain_sel;
  logic        way_sel;

  int tests = 0;
  int fails = 0;

  param_cache_control #(.s_offset(5), .s_index(3), .num_ways(2)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .da_read(da_read), .da_write_en(da_write_en), .da_index(da_index),
    .da_datain_sel(da_datain_sel), .way_sel(way_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    int          dw;
    int          df;
    int          lat;
    logic        way;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
    logic [63:0] fill_we;
    logic [63:0] resp_we;
  } vec_t;

  // Behavioural cache model: what each set holds, independent of FSM timing.
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  logic [23:0] m_tag   [8][2];
  bit          m_lru   [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 24'h0;
      end
    end
  endtask

  task automatic model_access(inout vec_t v);
    logic [23:0] tag;
    int idx, word, way;
    logic [63:0] lo;
    tag  = v.addr[31:8];
    idx  = int'(v.addr[7:5]);
    word = int'(v.addr[4:2]);
    lo   = 64'h0000_0000_ffff_ffff;
    way  = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
    v.wb = 1'b0; v.wb_addr = 32'h0; v.fill_addr = 32'h0; v.fill_we = 64'h0;
    if (way >= 0) begin
      v.lat = 2;
    end else begin
      way = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
      v.wb = m_valid[idx][way] && m_dirty[idx][way];
      v.wb_addr   = {m_tag[idx][way], 3'(idx), 5'b0};
      v.fill_addr = {tag, 3'(idx), 5'b0};
      v.fill_we   = lo << (32 * way);
      v.lat = 2 + (v.wb ? v.dw : 0) + v.df + 1;
      m_tag[idx][way] = tag; m_valid[idx][way] = 1'b1; m_dirty[idx][way] = 1'b0;
    end
    v.way = 1'(way);
    m_lru[idx] = (way == 0);
    v.resp_we = 64'h0;
    if (v.wr) begin
      for (int b = 0; b < 4; b++)
        if (v.be[b]) v.resp_we[way*32 + word*4 + b] = 1'b1;
      m_dirty[idx][way] = 1'b1;
    end
  endtask

  // Issue one CPU request, act as line memory, check every observable step.
  task automatic do_req(input vec_t v);
    int cyc, cnt;
    bit done, seen_wb, seen_fill;
    cyc = 0; cnt = 0; done = 0; seen_wb = 0; seen_fill = 0;
    @(posedge clk); #1;
    mem_address = v.addr; mem_byte_enable = v.be;
    mem_read = v.rd; mem_write = v.wr;
    while (!done && cyc < 100) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      cyc++;
      if (pmem_read && pmem_write) chk("pmem_both_high", 64'd1, 64'd0);
      if (mem_resp) begin
        chk("resp_latency", 64'(cyc), 64'(v.lat));
        chk("resp_way_sel", 64'(way_sel), 64'(v.way));
        chk("resp_we", da_write_en, v.resp_we);
        chk("resp_da_read", 64'(da_read), 64'd3);
        chk("resp_da_index", 64'(da_index), 64'(v.addr[7:5]));
        done = 1;
      end else if (pmem_write) begin
        if (!seen_wb) begin
          chk("wb_addr", 64'(pmem_address), 64'(v.wb_addr));
          chk("wb_way_sel", 64'(way_sel), 64'(v.way));
          chk("wb_da_read", 64'(da_read), 64'd3);
        end
        seen_wb = 1;
        cnt++;
        if (cnt >= v.dw) begin pmem_resp = 1'b1; cnt = 0; end
      end else if (pmem_read) begin
        if (!seen_fill) begin
          chk("fill_addr", 64'(pmem_address), 64'(v.fill_addr));
          chk("fill_da_read", 64'(da_read), 64'd0);
        end
        seen_fill = 1;
        cnt++;
        if (cnt >= v.df) begin
          pmem_resp = 1'b1; cnt = 0;
          #1;
          chk("fill_we", da_write_en, v.fill_we);
          chk("fill_datain_sel", 64'(da_datain_sel), 64'd1);
        end
      end
    end
    chk("resp_seen", 64'(done), 64'd1);
    chk("wb_seen", 64'(seen_wb), 64'(v.wb));
    chk("fill_seen", 64'(seen_fill), 64'(v.lat > 2));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 32'h0; mem_byte_enable = 4'h0; pmem_resp = 1'b0;
    model_reset();

    //        rd    wr    addr           be       dw df lat way   wb    wb_addr       fill_addr      fill_we                  resp_we
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 4'b0000, 1, 3, 6, 1'b0, 1'b0, 32'h0,        32'h0000_0040, 64'h0000_0000_ffff_ffff, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0044, 4'b0000, 1, 3, 2, 1'b0, 1'b0, 32'h0,        32'h0,         64'h0,                   64'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0048, 4'b0011, 1, 3, 2, 1'b0, 1'b0, 32'h0,        32'h0,         64'h0,                   64'h0000_0000_0000_0300};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_1040, 4'b0000, 1, 3, 6, 1'b1, 1'b0, 32'h0,        32'h0000_1040, 64'hffff_ffff_0000_0000, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_2040, 4'b0000, 2, 3, 8, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_2040, 64'h0000_0000_ffff_ffff, 64'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_1044, 4'b1111, 1, 3, 2, 1'b1, 1'b0, 32'h0,        32'h0,         64'h0,                   64'h0000_00f0_0000_0000};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0040, 4'b0000, 1, 2, 5, 1'b0, 1'b0, 32'h0,        32'h0000_0040, 64'h0000_0000_ffff_ffff, 64'h0};
    tbl[7] = '{1'b0, 1'b1, 32'h0000_7ffc, 4'b1000, 1, 1, 4, 1'b0, 1'b0, 32'h0,        32'h0000_7fe0, 64'h0000_0000_ffff_ffff, 64'h0000_0000_8000_0000};

    @(negedge clk); #1;
    chk("rst_mem_resp", 64'(mem_resp), 64'd0);
    chk("rst_pmem_rw", 64'({pmem_read, pmem_write}), 64'd0);
    chk("rst_pmem_addr", 64'(pmem_address), 64'd0);
    chk("rst_da_ctrl", 64'({da_read, da_datain_sel, way_sel, da_index}), 64'd0);
    chk("rst_da_we", da_write_en, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      model_access(v);
      do_req(tbl[i]);
    end

    // Reset arriving mid-fill must drop the memory request immediately.
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_address = 32'h0000_0040; mem_read = 1'b1;
    for (int k = 0; k < 10 && !pmem_read; k++) @(negedge clk);
    chk("rst_fill_req", 64'(pmem_read), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_fill_drop", 64'({pmem_read, pmem_write}), 64'd0);
    chk("rst_fill_resp", 64'(mem_resp), 64'd0);
    chk("rst_fill_we", da_write_en, 64'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    v = '{1'b1, 1'b0, 32'h0000_0040, 4'b0000, 1, 3, 0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0};
    model_access(v);
    do_req(v);
    v = '{1'b1, 1'b1, 32'h0000_0044, 4'b0101, 1, 3, 0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0};
    model_access(v);
    chk("both_high_we_model", v.resp_we, 64'h0000_0000_0000_0050);
    do_req(v);

    for (int i = 0; i < 40; i++) begin
      v.addr = {22'd0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 2'b00};
      v.wr = 1'($urandom_range(0, 1));
      v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.be = 4'($urandom_range(1, 15));
      v.dw = $urandom_range(1, 3);
      v.df = $urandom_range(1, 3);
      model_access(v);
      do_req(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
